// File: rtl/l2_bank_sched.sv
// ---------------------------------------------------------------------------
// l2_bank_sched
//
// Round-robin scheduler sharing four L2 cache banks among four requesters.
// Each cycle at most one requester whose target bank can accept is granted.
// The issued request is presented to the bank array one cycle later as a
// one-hot bank strobe with address and requester id. Each bank is kept
// occupied for BANK_LAT cycles. In the last occupied cycle a one-hot response
// strobe is returned to the requester that issued the access.
//
// Parameters:
//   ADDR_W   - request address width
//   BANK_LSB - LSB of the 2-bit bank field inside the address
//   BANK_LAT - bank occupancy / response latency in cycles (2..15)
//
// Ports:
//   clk          - clock, all logic on the rising edge
//   rstn         - synchronous active-low reset
//   req_valid    - per-requester request valid
//   req_addr     - packed per-requester addresses, requester i at
//                  [i*ADDR_W +: ADDR_W]
//   req_ready    - one-hot grant (combinational)
//   bank_req     - one-hot bank strobe for the issued access (registered)
//   bank_addr    - address of the issued access (registered, holds)
//   bank_id      - requester index of the issued access (registered, holds)
//   bank_busy    - per-bank occupied flag
//   resp_valid   - one-hot response strobe to the originating requester
//   conflict_cnt - saturating count of cycles in which a valid request was
//                  held off by a busy bank
//
// Optional feature macro: L2_SCHED_CONFLICT_CNT_EN
//   defined   - conflict_cnt is a live saturating counter
//   undefined - conflict_cnt is tied to zero
// ---------------------------------------------------------------------------
module l2_bank_sched #(
  parameter int ADDR_W   = 32,
  parameter int BANK_LSB = 6,
  parameter int BANK_LAT = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [3:0]            req_valid,
  input  logic [4*ADDR_W-1:0]   req_addr,
  output logic [3:0]            req_ready,
  output logic [3:0]            bank_req,
  output logic [ADDR_W-1:0]     bank_addr,
  output logic [1:0]            bank_id,
  output logic [3:0]            bank_busy,
  output logic [3:0]            resp_valid,
  output logic [15:0]           conflict_cnt
);

  localparam logic [3:0] LAT_C = 4'(BANK_LAT);

  // Per-bank occupancy counters and the requester id owed a response.
  logic [3:0]        cnt_r [4];
  logic [1:0]        id_r  [4];
  logic [1:0]        ptr_r;
  logic [3:0]        bank_req_r;
  logic [ADDR_W-1:0] bank_addr_r;
  logic [1:0]        bank_id_r;

  logic [1:0]        bank_of_s [4];
  logic [3:0]        eligible_s;
  logic              grant_vld_s;
  logic [1:0]        grant_idx_s;
  logic [1:0]        grant_bank_s;
  logic [ADDR_W-1:0] grant_addr_s;

  // Extract target bank per requester and decide eligibility.
  // A bank with cnt == 1 is finishing this cycle, so it may be reloaded now.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      bank_of_s[i]  = req_addr[i*ADDR_W+BANK_LSB +: 2];
      eligible_s[i] = req_valid[i] && (cnt_r[bank_of_s[i]] <= 4'd1);
    end
  end

  // Round-robin scan starting at ptr_r; first eligible requester wins.
  always_comb begin
    logic [1:0] cand;
    grant_vld_s = 1'b0;
    grant_idx_s = ptr_r;
    cand        = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_r + 2'(k);
      if (!grant_vld_s && eligible_s[cand]) begin
        grant_vld_s = 1'b1;
        grant_idx_s = cand;
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
    // No grants are offered while reset is held.
    if (!rstn) begin
      grant_vld_s = 1'b0;
    end else begin
      grant_vld_s = grant_vld_s;
    end
  end

  // Select bank and address of the winning requester.
  always_comb begin
    grant_bank_s = bank_of_s[grant_idx_s];
    grant_addr_s = {ADDR_W{1'b0}};
    for (int i = 0; i < 4; i++) begin
      if (grant_idx_s == 2'(i)) begin
        grant_addr_s = req_addr[i*ADDR_W +: ADDR_W];
      end else begin
        grant_addr_s = grant_addr_s;
      end
    end
  end

  // One-hot grant back to the requesters.
  always_comb begin
    req_ready = 4'b0000;
    if (grant_vld_s) begin
      req_ready[grant_idx_s] = 1'b1;
    end else begin
      req_ready = 4'b0000;
    end
  end

  // Bank occupancy counters and response ids; a grant reload wins over
  // the decrement, and the old id is still visible in the reload cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int b = 0; b < 4; b++) begin
        cnt_r[b] <= 4'd0;
        id_r[b]  <= 2'd0;
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (grant_vld_s && (grant_bank_s == 2'(b))) begin
          cnt_r[b] <= LAT_C;
          id_r[b]  <= grant_idx_s;
        end else if (cnt_r[b] != 4'd0) begin
          cnt_r[b] <= cnt_r[b] - 4'd1;
        end else begin
          cnt_r[b] <= cnt_r[b];
        end
      end
    end
  end

  // Round-robin pointer and registered issue interface to the bank array.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr_r       <= 2'd0;
      bank_req_r  <= 4'b0000;
      bank_addr_r <= {ADDR_W{1'b0}};
      bank_id_r   <= 2'd0;
    end else if (grant_vld_s) begin
      ptr_r       <= grant_idx_s + 2'd1;
      bank_req_r  <= 4'b0001 << grant_bank_s;
      bank_addr_r <= grant_addr_s;
      bank_id_r   <= grant_idx_s;
    end else begin
      ptr_r       <= ptr_r;
      bank_req_r  <= 4'b0000;
      bank_addr_r <= bank_addr_r;
      bank_id_r   <= bank_id_r;
    end
  end

  assign bank_req  = bank_req_r;
  assign bank_addr = bank_addr_r;
  assign bank_id   = bank_id_r;

  // Busy flags and response strobes decoded from the counter registers.
  always_comb begin
    bank_busy  = 4'b0000;
    resp_valid = 4'b0000;
    for (int b = 0; b < 4; b++) begin
      bank_busy[b] = (cnt_r[b] != 4'd0);
      if (cnt_r[b] == 4'd1) begin
        resp_valid[id_r[b]] = 1'b1;
      end else begin
        resp_valid = resp_valid;
      end
    end
  end

`ifdef L2_SCHED_CONFLICT_CNT_EN
  logic [3:0]  blocked_s;
  logic [15:0] conflict_r;

  // A request is blocked when its bank still has more than one cycle left.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      blocked_s[i] = req_valid[i] && (cnt_r[bank_of_s[i]] > 4'd1);
    end
  end

  // Saturating blocked-cycle counter, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      conflict_r <= 16'd0;
    end else if ((|blocked_s) && (conflict_r != 16'hFFFF)) begin
      conflict_r <= conflict_r + 16'd1;
    end else begin
      conflict_r <= conflict_r;
    end
  end

  assign conflict_cnt = conflict_r;
`else
  assign conflict_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_l2_bank_sched.sv
// ---------------------------------------------------------------------------
// tb_l2_bank_sched
//
// Self-checking bench for l2_bank_sched. The reference model tracks, per bank,
// the cycle number of its last grant and derives busy/eligible/response
// purely from elapsed time, plus a round-robin pointer and the last issue.
// Requesters follow a hold-until-ready protocol with optional withdrawal.
// ---------------------------------------------------------------------------
module tb_l2_bank_sched;

  localparam int ADDR_W   = 32;
  localparam int BANK_LSB = 6;
  localparam int LAT      = 4;

  logic                clk;
  logic                rstn;
  logic [3:0]          req_valid;
  logic [4*ADDR_W-1:0] req_addr;
  logic [3:0]          req_ready;
  logic [3:0]          bank_req;
  logic [ADDR_W-1:0]   bank_addr;
  logic [1:0]          bank_id;
  logic [3:0]          bank_busy;
  logic [3:0]          resp_valid;
  logic [15:0]         conflict_cnt;

  l2_bank_sched #(.ADDR_W(ADDR_W), .BANK_LSB(BANK_LSB), .BANK_LAT(LAT)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_ready    (req_ready),
    .bank_req     (bank_req),
    .bank_addr    (bank_addr),
    .bank_id      (bank_id),
    .bank_busy    (bank_busy),
    .resp_valid   (resp_valid),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model state (time based).
  int          last_g  [4];
  int          last_id [4];
  int          m_ptr;
  logic [3:0]  m_breq;
  logic [31:0] m_baddr;
  logic [1:0]  m_bid;
  int          m_conf;

  // Requester-side stimulus state.
  bit          pend   [4];
  logic [31:0] paddr  [4];
  bit          refill [4];
  bit          rand_mode;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int bank_of(input logic [31:0] a);
    return int'(a[BANK_LSB +: 2]);
  endfunction

  function automatic logic [31:0] mk_addr(input int bank);
    logic [31:0] a;
    a = $urandom;
    a[BANK_LSB +: 2] = 2'(bank);
    return a;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 4; b++) begin
      last_g[b]  = -100;
      last_id[b] = 0;
    end
    m_ptr   = 0;
    m_breq  = 4'b0000;
    m_baddr = 32'd0;
    m_bid   = 2'd0;
    m_conf  = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req_valid[i] = pend[i];
      req_addr[i*ADDR_W +: ADDR_W] = paddr[i];
    end
  endtask

  task automatic set_req(input int i, input int bank);
    pend[i]  = 1'b1;
    paddr[i] = mk_addr(bank);
    drive();
  endtask

  // One clock cycle: check at negedge, advance model at posedge, restimulate.
  task automatic step();
    logic [3:0] er;
    logic [3:0] eb;
    logic [3:0] ev;
    int         w;
    bit         blk;
    @(negedge clk);
    er = 4'b0000; eb = 4'b0000; ev = 4'b0000; w = -1; blk = 1'b0;
    for (int b = 0; b < 4; b++) begin
      eb[b] = (cyc >= last_g[b] + 1) && (cyc <= last_g[b] + LAT);
      if (cyc == last_g[b] + LAT) ev[last_id[b]] = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      if (pend[i] && (cyc < last_g[bank_of(paddr[i])] + LAT)) blk = 1'b1;
    end
    if (rstn) begin
      for (int k = 0; k < 4; k++) begin
        int i;
        i = (m_ptr + k) % 4;
        if (w < 0 && pend[i] && (cyc >= last_g[bank_of(paddr[i])] + LAT)) w = i;
      end
    end
    if (w >= 0) er[w] = 1'b1;
    check_eq("req_ready",  32'(req_ready),  32'(er));
    check_eq("bank_req",   32'(bank_req),   32'(m_breq));
    check_eq("bank_addr",  bank_addr,       m_baddr);
    check_eq("bank_id",    32'(bank_id),    32'(m_bid));
    check_eq("bank_busy",  32'(bank_busy),  32'(eb));
    check_eq("resp_valid", 32'(resp_valid), 32'(ev));
`ifdef L2_SCHED_CONFLICT_CNT_EN
    check_eq("conflict_cnt", 32'(conflict_cnt), 32'(m_conf));
`else
    check_eq("conflict_cnt", 32'(conflict_cnt), 32'd0);
`endif
    @(posedge clk);
    if (!rstn) begin
      model_reset();
    end else begin
      if (w >= 0) begin
        last_g[bank_of(paddr[w])]  = cyc;
        last_id[bank_of(paddr[w])] = w;
        m_ptr   = (w + 1) % 4;
        m_breq  = 4'b0001 << bank_of(paddr[w]);
        m_baddr = paddr[w];
        m_bid   = 2'(w);
      end else begin
        m_breq = 4'b0000;
      end
      if (blk && m_conf < 65535) m_conf++;
    end
    cyc++;
    #1;
    if (w >= 0) begin
      if (refill[w]) paddr[w] = mk_addr($urandom_range(0, 3));
      else           pend[w]  = 1'b0;
    end
    if (rand_mode) begin
      for (int i = 0; i < 4; i++) begin
        if (pend[i]) begin
          if ($urandom_range(0, 19) == 0) pend[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          pend[i]  = 1'b1;
          paddr[i] = mk_addr($urandom_range(0, 3));
        end
      end
    end
    drive();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      pend[i] = 1'b0; paddr[i] = 32'd0; refill[i] = 1'b0;
    end
    rand_mode = 1'b0;
    req_valid = 4'b0000;
    req_addr  = '0;
    rstn      = 1'b0;
    drive();
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    cyc = 0;
    // Reset-state checks with reset still held and a request present.
    set_req(3, 2);
    run(2);
    pend[3] = 1'b0;
    drive();
    rstn = 1'b1;
    run(2);

    // Single access to bank 1 from requester 0.
    pend[0] = 1'b1; paddr[0] = 32'h0000_0040; drive();
    run(8);

    // All four requesters to distinct banks.
    for (int i = 0; i < 4; i++) set_req(i, i);
    run(10);

    // All four requesters to bank 0.
    for (int i = 0; i < 4; i++) set_req(i, 0);
    run(22);

    // Busy bank 0 must not block a request to bank 2.
    set_req(0, 0);
    run(1);
    set_req(0, 0);
    set_req(1, 2);
    run(8);

    // Fairness: requesters 0 and 2 continuously valid.
    refill[0] = 1'b1; refill[2] = 1'b1;
    set_req(0, 0);
    set_req(2, 2);
    run(10);
    refill[0] = 1'b0; refill[2] = 1'b0;
    run(8);

    // Reset two cycles after a grant, then a fresh request.
    set_req(1, 1);
    run(2);
    rstn = 1'b0;
    run(1);
    rstn = 1'b1;
    run(3);
    set_req(2, 3);
    run(6);

    // Randomized traffic with occasional resets.
    rand_mode = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 299) == 0) rstn = 1'b0;
      else                             rstn = 1'b1;
      step();
    end
    rstn = 1'b1;
    rand_mode = 1'b0;
    run(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
